fract_muldiv_seq: RTL and testbench
===================================

# fract_muldiv_seq

Iterative mantissa datapath directly downstream of the FPU multiply/divide pre-normalisation stage. It consumes the two 24-bit fractions with hidden bits restored and produces either their 48-bit product or a 50-bit quotient with a 24-bit remainder. Results go to the multiply/divide post-normalisation stage. It trades area for latency with a one-bit-per-cycle shift-add / restoring-subtract engine under a start/done handshake.

## Interface
- MUL_ITER, 24, multiply iterations (fraction width)
- DIV_ITER, 50, divide iterations (quotient width)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch an operation; sampled only in IDLE or DONE
- op_div  in  1  0 = multiply, 1 = divide; sampled with start
- fracta  in  24  multiplicand / dividend fraction (hidden bit in [23])
- fractb  in  24  multiplier / divisor fraction
- busy  out  1  high while an operation is in flight (RUN)
- done  out  1  one-cycle pulse when results become valid
- prod  out  48  fracta*fractb (multiply result)
- quo  out  50  floor({fracta,26'b0} / fractb)
- rem  out  24  {fracta,26'b0} mod fractb
- div_by_zero  out  1  divide was launched with fractb == 0

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE or DONE with start=1: latch fracta, fractb, op_div. Load the iteration counter with MUL_ITER-1 or DIV_ITER-1. Clear the working registers. Go to RUN.
- IDLE or DONE with start=0: DONE → IDLE, IDLE stays IDLE.
- RUN with counter≠0: one iteration, decrement counter. RUN with counter==0: final iteration, write outputs, go to DONE.
- start during RUN is ignored. Inputs are not re-sampled and there is no queueing.
- Multiply: 48-bit accumulator. Each iteration, if the current LSB of the shifted multiplier is 1, add fracta into acc[47:24] with a 25-bit carry. Then shift {carry,acc} right by 1. After 24 iterations, prod = exact 48-bit product.
- Divide: restoring division, MSB-first over the 50-bit dividend {fracta,26'b0}, with a 25-bit partial remainder. Each iteration does: shift left by one and bring in the next dividend bit; if partial ≥ {1'b0,fractb}, subtract and set the quotient bit to 1, else set it to 0.
- Divide by zero is not special-cased in the datapath. Every compare succeeds, so quo = all ones (50'h3_FFFF_FFFF_FFFF) and rem = 0. div_by_zero = (fractb==0), captured at start, valid with done.
- Outputs prod, quo, rem and div_by_zero hold their values from DONE until the next DONE. A multiply leaves quo/rem/div_by_zero unchanged, and a divide leaves prod unchanged.

## Timing
- Reset values: busy=0, done=0, prod=0, quo=0, rem=0, div_by_zero=0, state=IDLE, counter=0.
- start sampled high at edge k → busy high from edge k until edge k+N, where N = 24 for multiply or 50 for divide.
- Results are registered at edge k+N. done is high from edge k+N to k+N+1, exactly one cycle.
- Back-to-back: start held high during DONE launches the next operation at edge k+N+1. done then drops and busy rises at that same edge. Throughput is one operation per N+1 cycles.
- Reset asserted mid-RUN: all state and outputs clear immediately and asynchronously. No done pulse is issued. The first start after reset is accepted at the first edge with rst low.
- Fixed latency, independent of operand values, including zero operands and denormal inputs (hidden bit 0).

## Structure
- Shared package fpu_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t
  - localparams MUL_ITER=24 and DIV_ITER=50
  - FRACT_W=24
- Counter width is $clog2(DIV_ITER), which is 6 bits.
- Single module, no sub-modules. Multiply and divide share one 25-bit adder/subtractor and one counter.

## Test plan
- Multiply 0x800000 × 0x800000 → prod = 48'h4000_0000_0000; done exactly 24 cycles after start; busy high for those 24 cycles.
- Multiply 0xFFFFFF × 0xFFFFFF → prod = 48'hFFFF_FE00_0001. Multiply 0x000000 × 0xABCDEF → prod = 0, still 24 cycles.
- Divide 0x800000 / 0x800000 → quo = 50'h400_0000, rem = 0, div_by_zero = 0, done 50 cycles after start. Divide 0xC00000 / 0x800000 → quo = 50'h600_0000, rem = 0.
- Divide 0x800000 / 0x000000 → quo = 50'h3_FFFF_FFFF_FFFF, rem = 0, div_by_zero = 1.
- Handshake:
  - start pulses during RUN are ignored; results still match the first operands.
  - start held through DONE launches a second multiply 1 cycle after done.
  - done is never wider than one cycle.
- Assert rst at cycle 10 of a divide → all outputs 0 immediately and no done pulse. A new multiply 0x800000 × 0xC00000 afterwards → prod = 48'h6000_0000_0000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the mantissa multiply/divide engine.
package fpu_pkg;

  localparam int unsigned FRACT_W  = 24;
  localparam int unsigned MUL_ITER = 24;
  localparam int unsigned DIV_ITER = 50;
  localparam int unsigned CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;

endpackage

// File: rtl/fract_muldiv_seq_if.sv
// Start/done handshake and operand/result bundle for fract_muldiv_seq.
interface fract_muldiv_seq_if;
  import fpu_pkg::*;

  logic                  start;
  logic                  op_div;
  logic [FRACT_W-1:0]    fracta;
  logic [FRACT_W-1:0]    fractb;
  logic                  busy;
  logic                  done;
  logic [2*FRACT_W-1:0]  prod;
  logic [DIV_ITER-1:0]   quo;
  logic [FRACT_W-1:0]    rem;
  logic                  div_by_zero;

  modport master (
    output start, op_div, fracta, fractb,
    input  busy, done, prod, quo, rem, div_by_zero
  );

  modport slave (
    input  start, op_div, fracta, fractb,
    output busy, done, prod, quo, rem, div_by_zero
  );

endinterface

// File: rtl/fract_muldiv_seq.sv
// One-bit-per-cycle mantissa multiplier (shift-add) and restoring divider
// sharing a single 25-bit adder/subtractor and iteration counter.
module fract_muldiv_seq
  import fpu_pkg::*;
(
  input logic               clk,
  input logic               rst,
  fract_muldiv_seq_if.slave bus
);

  localparam int unsigned PartW = FRACT_W + 1;

  muldiv_state_t        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_div_q, op_div_d;
  logic [FRACT_W-1:0]   a_q, a_d;
  logic [FRACT_W-1:0]   b_q, b_d;
  logic [FRACT_W-1:0]   mplr_q, mplr_d;
  // Multiply: accumulator in [47:0]. Divide: dividend shifts out of the top
  // while quotient bits shift in at the bottom.
  logic [DIV_ITER-1:0]  work_q, work_d;
  logic [FRACT_W-1:0]   part_q, part_d;
  logic [2*FRACT_W-1:0] prod_q, prod_d;
  logic [DIV_ITER-1:0]  quo_q, quo_d;
  logic [FRACT_W-1:0]   rem_q, rem_d;
  logic                 dbz_q, dbz_d;

  logic [PartW-1:0]     part_sh;
  logic [PartW-1:0]     add_lhs;
  logic [PartW-1:0]     add_rhs;
  logic [PartW:0]       add_sum;
  logic [PartW-1:0]     mul_hi;
  logic [2*FRACT_W-1:0] mul_next;
  logic                 div_ge;
  logic [DIV_ITER-1:0]  quo_next;

  // Shared datapath: add multiplicand into the top half, or subtract divisor via ~b + 1
  always_comb begin
    part_sh  = {part_q, work_q[DIV_ITER-1]};
    add_lhs  = op_div_q ? part_sh : {1'b0, work_q[2*FRACT_W-1:FRACT_W]};
    add_rhs  = op_div_q ? ~{1'b0, b_q} : {1'b0, a_q};
    add_sum  = {1'b0, add_lhs} + {1'b0, add_rhs} + {{PartW{1'b0}}, op_div_q};
    mul_hi   = mplr_q[0] ? add_sum[PartW-1:0] : {1'b0, work_q[2*FRACT_W-1:FRACT_W]};
    mul_next = {mul_hi, work_q[FRACT_W-1:1]};
    // Carry out of the subtract means partial >= divisor (always true for b == 0)
    div_ge   = add_sum[PartW];
    quo_next = {work_q[DIV_ITER-2:0], div_ge};
  end

  // Next-state: FSM, counter, operand latches, iteration and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    a_d      = a_q;
    b_d      = b_q;
    mplr_d   = mplr_q;
    work_d   = work_q;
    part_d   = part_q;
    prod_d   = prod_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          op_div_d = bus.op_div;
          a_d      = bus.fracta;
          b_d      = bus.fractb;
          mplr_d   = bus.fractb;
          part_d   = '0;
          work_d   = bus.op_div ? {bus.fracta, {(DIV_ITER-FRACT_W){1'b0}}} : '0;
          cnt_d    = bus.op_div ? CNT_W'(DIV_ITER - 1) : CNT_W'(MUL_ITER - 1);
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (op_div_q) begin
          work_d = quo_next;
          part_d = div_ge ? add_sum[FRACT_W-1:0] : part_sh[FRACT_W-1:0];
        end else begin
          work_d = {2'b00, mul_next};
          mplr_d = {1'b0, mplr_q[FRACT_W-1:1]};
        end
        if (cnt_q == '0) begin
          if (op_div_q) begin
            quo_d = quo_next;
            rem_d = div_ge ? add_sum[FRACT_W-1:0] : part_sh[FRACT_W-1:0];
            dbz_d = (b_q == '0);
          end else begin
            prod_d = mul_next;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      mplr_q   <= '0;
      work_q   <= '0;
      part_q   <= '0;
      prod_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mplr_q   <= mplr_d;
      work_q   <= work_d;
      part_q   <= part_d;
      prod_q   <= prod_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.prod        = prod_q;
  assign bus.quo         = quo_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_fract_muldiv_seq.sv
// Self-checking bench for fract_muldiv_seq against an arithmetic reference model.
module tb_fract_muldiv_seq;
  import fpu_pkg::*;

  logic clk;
  logic rst;
  fract_muldiv_seq_if bus ();

  fract_muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: results held since the last matching completion
  logic [47:0] exp_prod;
  logic [49:0] exp_quo;
  logic [23:0] exp_rem;
  logic        exp_dbz;

  task automatic model_op(input logic op, input logic [23:0] a, input logic [23:0] b);
    longint unsigned dvd;
    if (!op) begin
      exp_prod = 48'(longint'(a) * longint'(b));
    end else if (b == 24'd0) begin
      exp_quo = 50'h3_FFFF_FFFF_FFFF;
      exp_rem = 24'd0;
      exp_dbz = 1'b1;
    end else begin
      dvd     = longint'(a) * 64'd67108864; // a * 2^26
      exp_quo = 50'(dvd / longint'(b));
      exp_rem = 24'(dvd % longint'(b));
      exp_dbz = 1'b0;
    end
  endtask

  task automatic check_results(input string tag);
    n_vec++;
    if (bus.prod !== exp_prod) begin
      n_err++;
      $display("FAIL %s prod: got %h want %h", tag, bus.prod, exp_prod);
    end
    n_vec++;
    if (bus.quo !== exp_quo) begin
      n_err++;
      $display("FAIL %s quo: got %h want %h", tag, bus.quo, exp_quo);
    end
    n_vec++;
    if (bus.rem !== exp_rem) begin
      n_err++;
      $display("FAIL %s rem: got %h want %h", tag, bus.rem, exp_rem);
    end
    n_vec++;
    if (bus.div_by_zero !== exp_dbz) begin
      n_err++;
      $display("FAIL %s div_by_zero: got %b want %b", tag, bus.div_by_zero, exp_dbz);
    end
  endtask

  // Launch one op, optionally pulse start mid-run, check latency/busy/done/results
  task automatic do_op(input logic op, input logic [23:0] a, input logic [23:0] b,
                       input bit noise, input string tag);
    int n;
    int lat;
    n = op ? DIV_ITER : MUL_ITER;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = op;
    bus.fracta = a;
    bus.fractb = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    model_op(op, a, b);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL %s launch busy/done: got %b/%b want 1/0", tag, bus.busy, bus.done);
    end
    lat = 0;
    for (int i = 1; i <= n + 4; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      n_vec++;
      if (bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s busy cycle %0d: got %b want 1", tag, i, bus.busy);
      end
      if (noise && (i == 5 || i == 20)) begin
        bus.start  = 1'b1;
        bus.op_div = ~op;
        bus.fracta = 24'($urandom);
        bus.fractb = 24'($urandom);
      end
    end
    n_vec++;
    if (lat != n) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, n);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy at done: got %b want 0", tag, bus.busy);
    end
    check_results(tag);
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after done busy/done: got %b/%b want 0/0", tag, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    bus.fracta = '0;
    bus.fractb = '0;
    exp_prod = '0;
    exp_quo  = '0;
    exp_rem  = '0;
    exp_dbz  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset busy/done: got %b/%b want 0/0", bus.busy, bus.done);
    end
    check_results("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_op(1'b0, 24'h800000, 24'h800000, 1'b0, "mul_half_sq");
    do_op(1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, "mul_max");
    n_vec++;
    if (bus.prod !== 48'hFFFF_FE00_0001) begin
      n_err++;
      $display("FAIL mul_max const: got %h want %h", bus.prod, 48'hFFFF_FE00_0001);
    end
    do_op(1'b0, 24'h000000, 24'hABCDEF, 1'b0, "mul_zero");
    do_op(1'b1, 24'h800000, 24'h800000, 1'b0, "div_one");
    n_vec++;
    if (bus.quo !== 50'h400_0000) begin
      n_err++;
      $display("FAIL div_one const: got %h want %h", bus.quo, 50'h400_0000);
    end
    do_op(1'b1, 24'hC00000, 24'h800000, 1'b0, "div_1p5");
    do_op(1'b1, 24'h800000, 24'h000000, 1'b0, "div_zero");
    n_vec++;
    if (bus.quo !== 50'h3_FFFF_FFFF_FFFF || bus.div_by_zero !== 1'b1) begin
      n_err++;
      $display("FAIL div_zero const: got %h/%b want %h/1", bus.quo, bus.div_by_zero,
               50'h3_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [23:0] b;
    for (int i = 0; i < 24; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      if ($urandom_range(0, 3) != 0) a[23] = 1'b1;
      if ($urandom_range(0, 3) != 0) b[23] = 1'b1;
      if ($urandom_range(0, 9) == 0) b = '0;
      do_op(1'($urandom_range(0, 1)), a, b, 1'b0, "random");
    end
  endtask

  task automatic test_start_during_run();
    do_op(1'b1, 24'hD1E2F3, 24'h9A0B1C, 1'b1, "noise_div");
    do_op(1'b0, 24'hB4C5D6, 24'hE7F801, 1'b1, "noise_mul");
  endtask

  task automatic test_back_to_back();
    logic [23:0] a1, b1, a2, b2;
    int lat;
    a1 = 24'h800000 | 24'($urandom);
    b1 = 24'h800000 | 24'($urandom);
    a2 = 24'h800000 | 24'($urandom);
    b2 = 24'h800000 | 24'($urandom);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    bus.fracta = a1;
    bus.fractb = b1;
    @(posedge clk);
    #1;
    bus.fracta = a2;
    bus.fractb = b2;
    model_op(1'b0, a1, b1);
    lat = 0;
    for (int i = 1; i <= MUL_ITER + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat != MUL_ITER) begin
      n_err++;
      $display("FAIL b2b first latency: got %0d want %0d", lat, MUL_ITER);
    end
    check_results("b2b_first");
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b relaunch busy/done: got %b/%b want 1/0", bus.busy, bus.done);
    end
    model_op(1'b0, a2, b2);
    lat = 0;
    for (int i = 1; i <= MUL_ITER + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat != MUL_ITER) begin
      n_err++;
      $display("FAIL b2b second latency: got %0d want %0d", lat, MUL_ITER);
    end
    check_results("b2b_second");
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b done width: got %b want 0", bus.done);
    end
  endtask

  task automatic test_reset_mid_run();
    // Make sure both result groups hold nonzero values first
    do_op(1'b1, 24'hFFFFFF, 24'h812345, 1'b0, "pre_rst_div");
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_div = 1'b1;
    bus.fracta = 24'hFFFFFF;
    bus.fractb = 24'h912345;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_prod = '0;
    exp_quo  = '0;
    exp_rem  = '0;
    exp_dbz  = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid busy/done: got %b/%b want 0/0", bus.busy, bus.done);
    end
    check_results("rst_mid");
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        @(negedge clk);
        rst = 1'b0;
      end
      n_vec++;
      if (bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid stray done cycle %0d: got %b want 0", i, bus.done);
      end
    end
    do_op(1'b0, 24'h800000, 24'hC00000, 1'b0, "post_rst_mul");
    n_vec++;
    if (bus.prod !== 48'h6000_0000_0000) begin
      n_err++;
      $display("FAIL post_rst_mul const: got %h want %h", bus.prod, 48'h6000_0000_0000);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
